// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared-memory datapath, with variable-latency memory, pause and an illegal-opcode trap.
module mips_multicycle_ctrl #(
    parameter int USE_READY = 1,
    parameter int MEM_LAT   = 1,
    parameter int COUNT_W   = 32
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               pause,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         RegDst,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic [3:0]         state,
    output logic [COUNT_W-1:0] instr_count,
    output logic               illegal
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_IMM_EX    = 4'd10,
        S_I_WB      = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             busy_q;
    logic [CNT_W-1:0] wait_q;
    logic             mem_state;
    logic             fetch_idle;
    logic             access;
    logic             done;
    logic             retire;
    logic             unused_funct;

    assign unused_funct = ^funct;
    assign state        = state_q;

    // A paused FETCH only idles before its access starts; busy_q marks an access in flight.
    always_comb begin
        mem_state  = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
        fetch_idle = (state_q == S_FETCH) && !busy_q && pause;
        access     = mem_state && !fetch_idle;
        done       = (USE_READY != 0) ? mem_ready : (wait_q == LAT_LAST);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (access && done) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                          state_d = S_EXECUTE;
                    OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMM_EX;
                    default:                           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (done) state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: if (done) state_d = S_FETCH;
            S_EXECUTE:   state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_IMM_EX:    state_d = S_I_WB;
            S_I_WB:      state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_FETCH;
        endcase
        retire = (state_d == S_FETCH) &&
                 (state_q inside {S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_I_WB});
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            busy_q      <= 1'b0;
            wait_q      <= '0;
            instr_count <= '0;
            illegal     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (access && !done) begin
                busy_q <= 1'b1;
                if (USE_READY == 0) wait_q <= wait_q + CNT_W'(1);
            end else begin
                busy_q <= 1'b0;
                wait_q <= '0;
            end
            if (retire) instr_count <= instr_count + COUNT_W'(1);
            if (state_d == S_TRAP) illegal <= 1'b1;
        end
    end

    // Everything stays low while reset is held, so an aborted access writes nothing.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        MemtoReg    = 2'b00;
        RegDst      = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    if (access) begin
                        MemRead = 1'b1;
                        ALUSrcB = 2'b01;
                        if (done) begin
                            IRWrite = 1'b1;
                            PCWrite = 1'b1;
                        end
                    end
                end
                S_DECODE:    ALUSrcB = 2'b11;
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEM_READ: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEM_WB: begin
                    MemtoReg = 2'b01;
                    RegWrite = 1'b1;
                end
                S_MEM_WRITE: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_R_WB: begin
                    RegDst   = 2'b01;
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCSource    = 2'b01;
                    PCWriteCond = (opcode == OP_BNE) ? !zero : zero;
                end
                S_JUMP: begin
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                end
                S_IMM_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = 2'b11;
                end
                S_I_WB:      RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: one ready-handshake instance and one
// fixed-latency (MEM_LAT=3) instance, checked cycle by cycle against hand-written vectors.
module tb_mips_multicycle_ctrl;

    // Control word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite RegWrite ALUSrcA
    //                     MemtoReg[2] RegDst[2] ALUSrcB[2] ALUOp[2] PCSource[2]
    localparam logic [17:0] C_IDLE       = 18'b0;
    localparam logic [17:0] C_FETCH_DONE = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b01,2'b00,2'b00};
    localparam logic [17:0] C_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b01,2'b00,2'b00};
    localparam logic [17:0] C_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b11,2'b00,2'b00};
    localparam logic [17:0] C_MEM_ADDR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b10,2'b00,2'b00};
    localparam logic [17:0] C_MEM_READ   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00};
    localparam logic [17:0] C_MEM_WB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b01,2'b00,2'b00,2'b00,2'b00};
    localparam logic [17:0] C_MEM_WRITE  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00};
    localparam logic [17:0] C_EXEC       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b10,2'b00};
    localparam logic [17:0] C_R_WB       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b01,2'b00,2'b00,2'b00};
    localparam logic [17:0] C_BR_TAKEN   = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b01,2'b01};
    localparam logic [17:0] C_BR_NOT     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b01,2'b01};
    localparam logic [17:0] C_JUMP       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,2'b10};
    localparam logic [17:0] C_IMM_EX     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b10,2'b11,2'b00};
    localparam logic [17:0] C_I_WB       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,2'b00};

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        int          dut;
        string       name;
        logic [3:0]  st;
        logic [17:0] ctrl;
        logic [31:0] cnt;
        logic        ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       pause;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mr_a;
    logic       mr_b;

    logic a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_rw, a_asa;
    logic [1:0] a_m2r, a_rd, a_asb, a_aop, a_pcs;
    logic [3:0] a_state;
    logic [31:0] a_cnt;
    logic a_ill;
    logic b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_rw, b_asa;
    logic [1:0] b_m2r, b_rd, b_asb, b_aop, b_pcs;
    logic [3:0] b_state;
    logic [31:0] b_cnt;
    logic b_ill;
    logic [17:0] a_ctrl;
    logic [17:0] b_ctrl;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    assign a_ctrl = {a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_irw, a_rw, a_asa, a_m2r, a_rd, a_asb, a_aop, a_pcs};
    assign b_ctrl = {b_pcw, b_pcwc, b_iord, b_mr, b_mw, b_irw, b_rw, b_asa, b_m2r, b_rd, b_asb, b_aop, b_pcs};

    mips_multicycle_ctrl #(.USE_READY(1), .MEM_LAT(1), .COUNT_W(32)) dut_a (
        .CLOCK_50(clk), .reset(reset), .pause(pause), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mr_a),
        .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemRead(a_mr), .MemWrite(a_mw),
        .IRWrite(a_irw), .RegWrite(a_rw), .ALUSrcA(a_asa), .MemtoReg(a_m2r), .RegDst(a_rd),
        .ALUSrcB(a_asb), .ALUOp(a_aop), .PCSource(a_pcs), .state(a_state),
        .instr_count(a_cnt), .illegal(a_ill)
    );

    mips_multicycle_ctrl #(.USE_READY(0), .MEM_LAT(3), .COUNT_W(32)) dut_b (
        .CLOCK_50(clk), .reset(reset), .pause(pause), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mr_b),
        .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemRead(b_mr), .MemWrite(b_mw),
        .IRWrite(b_irw), .RegWrite(b_rw), .ALUSrcA(b_asa), .MemtoReg(b_m2r), .RegDst(b_rd),
        .ALUSrcB(b_asb), .ALUOp(b_aop), .PCSource(b_pcs), .state(b_state),
        .instr_count(b_cnt), .illegal(b_ill)
    );

    task automatic expect_out(input int d, input string nm, input logic [3:0] st,
                              input logic [17:0] c, input logic [31:0] n, input logic il);
        exp_t e;
        e.dut  = d;
        e.name = nm;
        e.st   = st;
        e.ctrl = c;
        e.cnt  = n;
        e.ill  = il;
        q.push_back(e);
    endtask

    task automatic check_now(input int d, input string nm, input logic [3:0] st,
                             input logic [17:0] c, input logic [31:0] n, input logic il);
        logic [3:0]  gs;
        logic [17:0] gc;
        logic [31:0] gn;
        logic        gi;
        gs = (d == 0) ? a_state : b_state;
        gc = (d == 0) ? a_ctrl  : b_ctrl;
        gn = (d == 0) ? a_cnt   : b_cnt;
        gi = (d == 0) ? a_ill   : b_ill;
        n_chk++;
        if (gs !== st || gc !== c || gn !== n || gi !== il)
            $display("FAIL %s (immediate): dut%0d got state=%0d ctrl=%b cnt=%0d illegal=%b, want state=%0d ctrl=%b cnt=%0d illegal=%b",
                     nm, d, gs, gc, gn, gi, st, c, n, il);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every falling edge, compare whatever the stimulus queued for this cycle.
    initial begin
        exp_t        e;
        logic [3:0]  act_st;
        logic [17:0] act_c;
        logic [31:0] act_n;
        logic        act_i;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e      = q.pop_front();
                act_st = (e.dut == 0) ? a_state : b_state;
                act_c  = (e.dut == 0) ? a_ctrl  : b_ctrl;
                act_n  = (e.dut == 0) ? a_cnt   : b_cnt;
                act_i  = (e.dut == 0) ? a_ill   : b_ill;
                n_chk++;
                if (act_st === e.st && act_c === e.ctrl && act_n === e.cnt && act_i === e.ill)
                    n_pass++;
                else
                    $display("FAIL %s: dut%0d got state=%0d ctrl=%b cnt=%0d illegal=%b, want state=%0d ctrl=%b cnt=%0d illegal=%b",
                             e.name, e.dut, act_st, act_c, act_n, act_i, e.st, e.ctrl, e.cnt, e.ill);
            end
        end
    end

    initial begin
        reset = 1'b1; pause = 1'b0; opcode = OP_R; funct = 6'h20; zero = 1'b0;
        mr_a = 1'b1; mr_b = 1'b1;
        tick();
        check_now(0, "reset_state_a", 4'd0, C_IDLE, 0, 1'b0);
        check_now(1, "reset_state_b", 4'd0, C_IDLE, 0, 1'b0);
        expect_out(0, "reset_a", 4'd0, C_IDLE, 0, 1'b0);
        expect_out(1, "reset_b", 4'd0, C_IDLE, 0, 1'b0);
        tick();

        // R-type with immediate ready
        reset = 1'b0;
        expect_out(0, "r_fetch",  4'd0, C_FETCH_DONE, 0, 1'b0); tick();
        expect_out(0, "r_decode", 4'd1, C_DECODE,     0, 1'b0); tick();
        expect_out(0, "r_exec",   4'd6, C_EXEC,       0, 1'b0); tick();
        expect_out(0, "r_wb",     4'd7, C_R_WB,       0, 1'b0); tick();

        // lw with 3 stall cycles, pause raised mid-instruction
        opcode = OP_LW;
        expect_out(0, "lw_fetch",  4'd0, C_FETCH_DONE, 1, 1'b0); tick();
        expect_out(0, "lw_decode", 4'd1, C_DECODE,     1, 1'b0); tick();
        pause = 1'b1; mr_a = 1'b0;
        expect_out(0, "lw_addr",   4'd2, C_MEM_ADDR,   1, 1'b0); tick();
        for (int i = 0; i < 4; i++) begin
            mr_a = (i == 3);
            expect_out(0, "lw_read", 4'd3, C_MEM_READ, 1, 1'b0); tick();
        end
        expect_out(0, "lw_wb", 4'd4, C_MEM_WB, 1, 1'b0); tick();
        for (int i = 0; i < 5; i++) begin
            expect_out(0, "pause_idle", 4'd0, C_IDLE, 2, 1'b0); tick();
        end

        // beq / bne with zero=0
        pause = 1'b0; opcode = OP_BEQ; zero = 1'b0;
        expect_out(0, "beq_fetch",  4'd0, C_FETCH_DONE, 2, 1'b0); tick();
        expect_out(0, "beq_decode", 4'd1, C_DECODE,     2, 1'b0); tick();
        expect_out(0, "beq_z0",     4'd8, C_BR_NOT,     2, 1'b0); tick();
        opcode = OP_BNE;
        expect_out(0, "bne_fetch",  4'd0, C_FETCH_DONE, 3, 1'b0); tick();
        expect_out(0, "bne_decode", 4'd1, C_DECODE,     3, 1'b0); tick();
        expect_out(0, "bne_z0",     4'd8, C_BR_TAKEN,   3, 1'b0); tick();

        // jump and ori
        opcode = OP_J;
        expect_out(0, "j_fetch",    4'd0, C_FETCH_DONE, 4, 1'b0); tick();
        expect_out(0, "j_decode",   4'd1, C_DECODE,     4, 1'b0); tick();
        expect_out(0, "j_jump",     4'd9, C_JUMP,       4, 1'b0); tick();
        opcode = OP_ORI;
        expect_out(0, "ori_fetch",  4'd0,  C_FETCH_DONE, 5, 1'b0); tick();
        expect_out(0, "ori_decode", 4'd1,  C_DECODE,     5, 1'b0); tick();
        expect_out(0, "ori_ex",     4'd10, C_IMM_EX,     5, 1'b0); tick();
        expect_out(0, "ori_wb",     4'd11, C_I_WB,       5, 1'b0); tick();

        // sw with stalled fetch; pause during an active fetch is ignored
        opcode = OP_SW; mr_a = 1'b0;
        expect_out(0, "sw_fetch_wait",  4'd0, C_FETCH_WAIT, 6, 1'b0); tick();
        pause = 1'b1;
        expect_out(0, "sw_fetch_pause", 4'd0, C_FETCH_WAIT, 6, 1'b0); tick();
        mr_a = 1'b1;
        expect_out(0, "sw_fetch_done",  4'd0, C_FETCH_DONE, 6, 1'b0); tick();
        pause = 1'b0;
        expect_out(0, "sw_decode", 4'd1, C_DECODE,    6, 1'b0); tick();
        mr_a = 1'b0;
        expect_out(0, "sw_addr",   4'd2, C_MEM_ADDR,  6, 1'b0); tick();
        expect_out(0, "sw_wait",   4'd5, C_MEM_WRITE, 6, 1'b0); tick();
        mr_a = 1'b1;
        expect_out(0, "sw_done",   4'd5, C_MEM_WRITE, 6, 1'b0); tick();

        // illegal opcode trap, then async reset mid-cycle
        opcode = OP_BAD;
        expect_out(0, "bad_fetch",  4'd0,  C_FETCH_DONE, 7, 1'b0); tick();
        expect_out(0, "bad_decode", 4'd1,  C_DECODE,     7, 1'b0); tick();
        expect_out(0, "trap",       4'd12, C_IDLE,       7, 1'b1); tick();
        opcode = OP_R;
        expect_out(0, "trap_hold1", 4'd12, C_IDLE,       7, 1'b1); tick();
        expect_out(0, "trap_hold2", 4'd12, C_IDLE,       7, 1'b1); tick();
        #1 reset = 1'b1;
        #1 check_now(0, "async_rst_now", 4'd0, C_IDLE, 0, 1'b0);
        expect_out(0, "async_rst_a", 4'd0, C_IDLE, 0, 1'b0);
        expect_out(1, "async_rst_b", 4'd0, C_IDLE, 0, 1'b0);
        tick();
        opcode = OP_SW;
        expect_out(1, "rst_hold_b", 4'd0, C_IDLE, 0, 1'b0); tick();

        // fixed latency 3: mem_ready is tied high on this instance and must be ignored
        reset = 1'b0;
        expect_out(1, "b_fetch_w1", 4'd0, C_FETCH_WAIT, 0, 1'b0); tick();
        expect_out(1, "b_fetch_w2", 4'd0, C_FETCH_WAIT, 0, 1'b0); tick();
        check_now(1, "b_fetch_expired", 4'd0, C_FETCH_DONE, 0, 1'b0);
        expect_out(1, "b_fetch_d",  4'd0, C_FETCH_DONE, 0, 1'b0); tick();
        expect_out(1, "b_decode",   4'd1, C_DECODE,     0, 1'b0); tick();
        expect_out(1, "b_addr",     4'd2, C_MEM_ADDR,   0, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            expect_out(1, "b_write", 4'd5, C_MEM_WRITE, 0, 1'b0); tick();
        end
        expect_out(1, "b_fetch2_w1", 4'd0, C_FETCH_WAIT, 1, 1'b0); tick();
        expect_out(1, "b_fetch2_w2", 4'd0, C_FETCH_WAIT, 1, 1'b0); tick();
        expect_out(1, "b_fetch2_d",  4'd0, C_FETCH_DONE, 1, 1'b0); tick();

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
